noc_pe_endpoint: RTL and testbench

NOC_PE_ENDPOINT -- requirements
Module: noc_pe_endpoint

---
 rtl/noc_pe_endpoint.sv | 103 ++++++++++
 tb/tb_noc_pe_endpoint.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/noc_pe_endpoint.sv
// Processing-element endpoint on a 2D mesh NoC: a TX FIFO feeds the switch PE port,
// and an RX FIFO collects correctly addressed payloads, counting drops and misroutes.
module noc_pe_endpoint #(
    parameter int X           = 2,
    parameter int Y           = 2,
    parameter int data_width  = 32,
    parameter int x_size      = 1,
    parameter int y_size      = 1,
    parameter int total_width = x_size + y_size + data_width,
    parameter int x_coord     = 0,
    parameter int y_coord     = 0,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_valid_tx,
    input  logic [data_width-1:0]  i_data_tx,
    input  logic [x_size-1:0]      i_dest_x,
    input  logic [y_size-1:0]      i_dest_y,
    output logic                   o_ready_tx,
    output logic                   o_valid_noc,
    output logic [total_width-1:0] o_data_noc,
    input  logic                   i_ready_noc,
    input  logic                   i_valid_noc,
    input  logic [total_width-1:0] i_data_noc,
    output logic                   o_valid_rx,
    output logic [data_width-1:0]  o_data_rx,
    input  logic                   i_ready_rx,
    output logic [7:0]             o_drop_cnt,
    output logic [7:0]             o_misroute_cnt
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    // An endpoint placed outside the mesh can never be a legal destination.
    localparam bit COORD_OK = (x_coord < X) && (y_coord < Y);

    logic [total_width-1:0] tx_mem_q [TX_DEPTH];
    logic [data_width-1:0]  rx_mem_q [RX_DEPTH];
    logic [TX_AW:0]         tx_wr_q, tx_rd_q;
    logic [RX_AW:0]         rx_wr_q, rx_rd_q;
    logic                   ready_en_q;
    logic [7:0]             drop_cnt_q, misroute_cnt_q;

    logic tx_full, tx_empty, tx_push, tx_pop;
    logic rx_full, rx_empty, rx_push, rx_pop;
    logic addr_ok, drop, misroute;
    logic [x_size-1:0] hdr_x;
    logic [y_size-1:0] hdr_y;

    // TX side
    assign tx_full  = (tx_wr_q[TX_AW] != tx_rd_q[TX_AW]) &&
                      (tx_wr_q[TX_AW-1:0] == tx_rd_q[TX_AW-1:0]);
    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign o_ready_tx  = ready_en_q & ~tx_full;
    assign o_valid_noc = ~tx_empty;
    assign o_data_noc  = tx_mem_q[tx_rd_q[TX_AW-1:0]];
    assign tx_push = i_valid_tx & o_ready_tx;
    assign tx_pop  = o_valid_noc & i_ready_noc;

    // RX side: header check, then push unless full with no pop this cycle
    assign hdr_x    = i_data_noc[data_width+x_size-1:data_width];
    assign hdr_y    = i_data_noc[total_width-1:data_width+x_size];
    assign addr_ok  = COORD_OK && (hdr_x == x_size'(x_coord)) && (hdr_y == y_size'(y_coord));
    assign rx_full  = (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]) &&
                      (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]);
    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign o_valid_rx = ~rx_empty;
    assign o_data_rx  = rx_mem_q[rx_rd_q[RX_AW-1:0]];
    assign rx_pop   = o_valid_rx & i_ready_rx;
    assign rx_push  = i_valid_noc & addr_ok & (~rx_full | rx_pop);
    assign drop     = i_valid_noc & addr_ok & rx_full & ~rx_pop;
    assign misroute = i_valid_noc & ~addr_ok;

    assign o_drop_cnt     = drop_cnt_q;
    assign o_misroute_cnt = misroute_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wr_q        <= '0;
            tx_rd_q        <= '0;
            rx_wr_q        <= '0;
            rx_rd_q        <= '0;
            ready_en_q     <= 1'b0;
            drop_cnt_q     <= '0;
            misroute_cnt_q <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            if (drop && drop_cnt_q != 8'hFF)         drop_cnt_q     <= drop_cnt_q + 8'd1;
            if (misroute && misroute_cnt_q != 8'hFF) misroute_cnt_q <= misroute_cnt_q + 8'd1;
        end
    end

    // Storage is deliberately unreset; data outputs are meaningless while valid is low.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q[TX_AW-1:0]] <= {i_dest_y, i_dest_x, i_data_tx};
        if (rx_push) rx_mem_q[rx_wr_q[RX_AW-1:0]] <= i_data_noc[data_width-1:0];
    end
endmodule

// File: tb/tb_noc_pe_endpoint.sv
// Scoreboard bench for noc_pe_endpoint at mesh position (1,0) on a 2x2 mesh.
module tb_noc_pe_endpoint;
    localparam int DW = 32;
    localparam int TW = 34;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_valid_tx;
    logic [DW-1:0] i_data_tx;
    logic          i_dest_x, i_dest_y;
    logic          o_ready_tx, o_valid_noc;
    logic [TW-1:0] o_data_noc;
    logic          i_ready_noc, i_valid_noc;
    logic [TW-1:0] i_data_noc;
    logic          o_valid_rx;
    logic [DW-1:0] o_data_rx;
    logic          i_ready_rx;
    logic [7:0]    o_drop_cnt, o_misroute_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic [TW-1:0] tx_exp[$];
    logic [DW-1:0] rx_exp[$];

    noc_pe_endpoint #(
        .X(2), .Y(2), .data_width(DW), .x_size(1), .y_size(1), .total_width(TW),
        .x_coord(1), .y_coord(0), .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_valid_tx(i_valid_tx), .i_data_tx(i_data_tx),
        .i_dest_x(i_dest_x), .i_dest_y(i_dest_y), .o_ready_tx(o_ready_tx),
        .o_valid_noc(o_valid_noc), .o_data_noc(o_data_noc), .i_ready_noc(i_ready_noc),
        .i_valid_noc(i_valid_noc), .i_data_noc(i_data_noc),
        .o_valid_rx(o_valid_rx), .o_data_rx(o_data_rx), .i_ready_rx(i_ready_rx),
        .o_drop_cnt(o_drop_cnt), .o_misroute_cnt(o_misroute_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: compare every handshake at the falling edge.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (o_valid_noc && i_ready_noc) begin
                if (tx_exp.size() == 0) chk("tx_unexpected", 64'(o_data_noc), 64'hX);
                else chk("tx_data", 64'(o_data_noc), 64'(tx_exp.pop_front()));
            end
            if (o_valid_rx && i_ready_rx) begin
                if (rx_exp.size() == 0) chk("rx_unexpected", 64'(o_data_rx), 64'hX);
                else chk("rx_data", 64'(o_data_rx), 64'(rx_exp.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic tx_drive(input logic [DW-1:0] d, input logic dx, input logic dy);
        i_valid_tx = 1'b1; i_data_tx = d; i_dest_x = dx; i_dest_y = dy;
        tx_exp.push_back({dy, dx, d});
        step();
        i_valid_tx = 1'b0;
    endtask

    task automatic rx_drive(input logic [TW-1:0] f, input bit expect_store);
        i_valid_noc = 1'b1; i_data_noc = f;
        if (expect_store) rx_exp.push_back(f[DW-1:0]);
        step();
        i_valid_noc = 1'b0;
    endtask

    task automatic wait_drained(input string tag);
        int n = 0;
        while ((tx_exp.size() != 0 || rx_exp.size() != 0) && n < 50) begin
            step(); n++;
        end
        chk(tag, 64'(tx_exp.size() + rx_exp.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; i_valid_tx = 1'b0; i_data_tx = '0; i_dest_x = 1'b0; i_dest_y = 1'b0;
        i_ready_noc = 1'b1; i_valid_noc = 1'b0; i_data_noc = '0; i_ready_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_tx", 64'(o_ready_tx), 64'd0);
        chk("rst_valid_noc", 64'(o_valid_noc), 64'd0);
        chk("rst_valid_rx", 64'(o_valid_rx), 64'd0);
        chk("rst_cnts", 64'({o_drop_cnt, o_misroute_cnt}), 64'd0);
        rstn = 1'b1;
        #1 chk("ready_before_edge", 64'(o_ready_tx), 64'd0);
        step();
        chk("ready_after_edge", 64'(o_ready_tx), 64'd1);

        // Single flit to (0,1): one-cycle latency, popped immediately
        tx_drive(32'hA5A5_0001, 1'b0, 1'b1);
        chk("tx_latency", 64'(o_valid_noc), 64'd1);
        chk("tx_flit", 64'(o_data_noc), 64'h2_A5A5_0001);
        step();
        chk("tx_popped", 64'(o_valid_noc), 64'd0);
        wait_drained("drain_single");

        // Backpressure: 4 accepted (incl. self-addressed), 5th refused, head stable
        i_ready_noc = 1'b0;
        tx_drive(32'h1111_0000, 1'b1, 1'b0);
        tx_drive(32'h2222_0001, 1'b0, 1'b0);
        tx_drive(32'h3333_0002, 1'b1, 1'b1);
        tx_drive(32'h4444_0003, 1'b0, 1'b1);
        chk("tx_full_ready", 64'(o_ready_tx), 64'd0);
        i_valid_tx = 1'b1; i_data_tx = 32'hBAD0_0005; i_dest_x = 1'b0; i_dest_y = 1'b0;
        step(); step();
        i_valid_tx = 1'b0;
        chk("tx_head_stable", 64'(o_data_noc), 64'h1_1111_0000);
        i_ready_noc = 1'b1;
        repeat (4) step();
        chk("tx_drained_4", 64'(o_valid_noc), 64'd0);
        wait_drained("drain_burst");

        // RX overflow: 6 flits, 4 stored, 2 dropped
        i_ready_rx = 1'b0;
        rx_drive(34'h1_0000_0000, 1'b1);
        chk("rx_latency", 64'(o_valid_rx), 64'd1);
        for (int k = 1; k < 6; k++) rx_drive(34'h1_0000_0000 | 34'(k), k < 4);
        chk("rx_drop_cnt", 64'(o_drop_cnt), 64'd2);
        i_ready_rx = 1'b1;
        wait_drained("drain_rx");

        // Full RX with a simultaneous pop accepts the flit
        i_ready_rx = 1'b0;
        for (int k = 10; k < 14; k++) rx_drive(34'h1_0000_0000 | 34'(k), 1'b1);
        i_ready_rx = 1'b1;
        rx_drive(34'h1_0000_000E, 1'b1);
        chk("rx_full_pop_nodrop", 64'(o_drop_cnt), 64'd2);
        wait_drained("drain_rx2");

        // Misrouted flit to (1,1), then saturation
        rx_drive(34'h3_DEAD_BEEF, 1'b0);
        chk("misroute_one", 64'(o_misroute_cnt), 64'd1);
        chk("misroute_no_rx", 64'(o_valid_rx), 64'd0);
        for (int k = 0; k < 299; k++) rx_drive(34'h3_DEAD_BEEF, 1'b0);
        chk("misroute_sat", 64'(o_misroute_cnt), 64'd255);
        chk("drop_unchanged", 64'(o_drop_cnt), 64'd2);

        // Reset with 3 TX and 2 RX entries held
        i_ready_noc = 1'b0; i_ready_rx = 1'b0;
        for (int k = 0; k < 3; k++) tx_drive(32'hC0DE_0000 | 32'(k), 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) rx_drive(34'h1_FACE_0000 | 34'(k), 1'b1);
        chk("held_valids", 64'({o_valid_noc, o_valid_rx}), 64'b11);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valids", 64'({o_valid_noc, o_valid_rx, o_ready_tx}), 64'd0);
        chk("mid_rst_cnts", 64'({o_drop_cnt, o_misroute_cnt}), 64'd0);
        tx_exp.delete(); rx_exp.delete();
        step();
        rstn = 1'b1;
        i_ready_noc = 1'b1; i_ready_rx = 1'b1;
        repeat (3) begin
            step();
            chk("post_rst_quiet", 64'({o_valid_noc, o_valid_rx}), 64'd0);
        end
        tx_drive(32'h0BAD_F00D, 1'b1, 1'b0);
        rx_drive(34'h1_1234_5678, 1'b1);
        wait_drained("drain_post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
